// File: rtl/uart_transceptor.sv
// uart_transceptor: full-duplex UART with a first-word-fall-through receive
// FIFO, ready/valid handshakes on both sides and sticky receive error flags.
// Optional feature macro: UART_PARITY_EN adds one parity bit (even, or odd
// when PARITY_ODD=1) after the data bits in both directions.
module uart_transceptor #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_serial,
  output logic                 tx_serial,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_ready,
  output logic                 rx_overflow,
  output logic                 rx_frame_error,
  output logic                 rx_parity_error,
  input  logic                 err_clear
);

  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W     = $clog2(STOP_CLKS + 1);
  localparam int BIT_W     = $clog2(DATA_BITS);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
  localparam logic [BIT_W-1:0] IDX_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  // Reject parameter sets the datapath cannot represent.
  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
    $fatal(1, "uart_transceptor: illegal parameter set");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } uart_state_t;

  // ---------------------------------------------------------------- RX sync
  logic rx_p0, rx_p1, rx_p2;
  logic rx_fall;

  // Two-flop synchroniser plus one history flop for falling-edge detection;
  // all three idle high so reset release never looks like a start bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx_serial;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign rx_fall = rx_p2 & ~rx_p1;

  // ---------------------------------------------------------------- RX FSM
  uart_state_t          rx_state;
  logic [CNT_W-1:0]     rx_cnt;
  logic [BIT_W-1:0]     rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_tick;
  logic                 stop_sample;
  logic                 parity_ok;
  logic                 frame_push;
  logic                 frame_err_set;

  assign rx_tick = (rx_cnt == BIT_LAST);

  // Receive sequencer: mid-bit sampling timed from the detected falling edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
    end else begin
      case (rx_state)
        ST_IDLE: begin
          rx_cnt <= '0;
          if (rx_fall) rx_state <= ST_START;
        end
        ST_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_idx <= '0;
            rx_state <= rx_p1 ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (rx_tick) begin
            rx_cnt <= '0;
            if (rx_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
              rx_state <= ST_PARITY;
`else
              rx_state <= ST_STOP;
`endif
            end else begin
              rx_idx <= rx_idx + BIT_W'(1);
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_state <= ST_STOP;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_state <= ST_IDLE;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: begin
          rx_cnt   <= '0;
          rx_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Data bits arrive LSB first, so shift in from the top.
  always_ff @(posedge clock) begin
    if (rx_state == ST_DATA && rx_tick) rx_shift <= {rx_p1, rx_shift[DATA_BITS-1:1]};
  end

  assign stop_sample = (rx_state == ST_STOP) && rx_tick;

`ifdef UART_PARITY_EN
  logic rx_par_bit;

  // Received parity bit, checked together with the data at the stop sample.
  always_ff @(posedge clock) begin
    if (rx_state == ST_PARITY && rx_tick) rx_par_bit <= rx_p1;
  end

  assign parity_ok = (((^rx_shift) ^ rx_par_bit) == 1'(PARITY_ODD));
`else
  assign parity_ok = 1'b1;
`endif

  assign frame_push    = stop_sample & rx_p1 & parity_ok;
  assign frame_err_set = stop_sample & ~rx_p1;

  // ---------------------------------------------------------------- RX FIFO
  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       fifo_cnt;
  logic                 fifo_full, fifo_pop, fifo_push, fifo_drop;

  assign fifo_full = (fifo_cnt == FIFO_FULL);
  assign rx_valid  = (fifo_cnt != '0);
  assign fifo_pop  = rx_valid & rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign fifo_push = frame_push & (~fifo_full | fifo_pop);
  assign fifo_drop = frame_push & fifo_full & ~fifo_pop;
  assign rx_data   = rx_valid ? fifo_mem[rd_ptr] : '0;

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clock) begin
    if (fifo_push) fifo_mem[wr_ptr] <= rx_shift;
  end

  // ---------------------------------------------------------------- flags
  // Sticky error flags; a new error in the clear cycle wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_overflow    <= 1'b0;
      rx_frame_error <= 1'b0;
    end else begin
      if (fifo_drop)          rx_overflow <= 1'b1;
      else if (err_clear)     rx_overflow <= 1'b0;
      if (frame_err_set)      rx_frame_error <= 1'b1;
      else if (err_clear)     rx_frame_error <= 1'b0;
    end
  end

`ifdef UART_PARITY_EN
  // Sticky parity flag; a bad stop bit is reported as a frame error instead.
  always_ff @(posedge clock) begin
    if (reset)                                     rx_parity_error <= 1'b0;
    else if (stop_sample && rx_p1 && !parity_ok)   rx_parity_error <= 1'b1;
    else if (err_clear)                            rx_parity_error <= 1'b0;
  end
`else
  assign rx_parity_error = 1'b0;
`endif

  // ---------------------------------------------------------------- TX FSM
  uart_state_t          tx_state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [BIT_W-1:0]     tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_tick;
  logic                 tx_accept;

  assign tx_tick   = (tx_cnt == BIT_LAST);
  assign tx_accept = (tx_state == ST_IDLE) && tx_valid && tx_ready;

`ifdef UART_PARITY_EN
  logic tx_par_bit;
`endif

  // Transmit byte register: loaded on acceptance, shifted after each data bit.
  always_ff @(posedge clock) begin
    if (tx_accept) begin
      tx_shift <= tx_data;
`ifdef UART_PARITY_EN
      tx_par_bit <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
    end else if (tx_state == ST_DATA && tx_tick) begin
      tx_shift <= tx_shift >> 1;
    end
  end

  // Transmit sequencer with registered line and ready outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state  <= ST_IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          tx_cnt    <= '0;
          tx_serial <= 1'b1;
          if (tx_valid && tx_ready) begin
            tx_state  <= ST_START;
            tx_serial <= 1'b0;
            tx_ready  <= 1'b0;
          end
        end
        ST_START: begin
          if (tx_tick) begin
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_state  <= ST_DATA;
            tx_serial <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            if (tx_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
              tx_state  <= ST_PARITY;
              tx_serial <= tx_par_bit;
`else
              tx_state  <= ST_STOP;
              tx_serial <= 1'b1;
`endif
            end else begin
              tx_idx    <= tx_idx + BIT_W'(1);
              tx_serial <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (tx_tick) begin
            tx_cnt    <= '0;
            tx_state  <= ST_STOP;
            tx_serial <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (tx_cnt == STOP_LAST) begin
            tx_cnt   <= '0;
            tx_state <= ST_IDLE;
            tx_ready <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        default: begin
          tx_cnt    <= '0;
          tx_state  <= ST_IDLE;
          tx_serial <= 1'b1;
          tx_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceptor.sv
// Directed self-checking bench for uart_transceptor (CLKS_PER_BIT=16,
// FIFO_DEPTH=4). Expected RX bytes and TX line bits go through queues.
module tb_uart_transceptor;

  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam int SB   = 1;
  localparam int FD   = 4;
  localparam int PODD = 0;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic          clock = 1'b0;
  logic          reset, rx_serial, tx_serial, tx_valid, tx_ready;
  logic          rx_valid, rx_ready, rx_overflow, rx_frame_error;
  logic          rx_parity_error, err_clear;
  logic [DB-1:0] tx_data, rx_data;

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [DB-1:0] sb_q[$];
  logic          tx_q[$];
  int            model_cnt = 0;
  logic          exp_ovf = 1'b0;

  always #5 clock = ~clock;

  uart_transceptor #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB),
    .FIFO_DEPTH(FD), .PARITY_ODD(PODD)
  ) dut (
    .clock(clock), .reset(reset), .rx_serial(rx_serial), .tx_serial(tx_serial),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_overflow(rx_overflow), .rx_frame_error(rx_frame_error),
    .rx_parity_error(rx_parity_error), .err_clear(err_clear)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_errors();
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
  endtask

  // Drive one serial frame and record what the receiver should retain.
  task automatic send_rx(input logic [DB-1:0] d, input logic stop_lvl, input logic par_flip);
    logic par;
    par = (^d) ^ 1'(PODD) ^ par_flip;
    rx_serial = 1'b0;
    tick(CPB);
    for (int i = 0; i < DB; i++) begin
      rx_serial = d[i];
      tick(CPB);
    end
    if (PB != 0) begin
      rx_serial = par;
      tick(CPB);
    end
    rx_serial = stop_lvl;
    tick(CPB);
    for (int i = 1; i < SB; i++) begin
      rx_serial = 1'b1;
      tick(CPB);
    end
    rx_serial = 1'b1;
    tick(4);
    if (stop_lvl && (PB == 0 || !par_flip)) begin
      if (model_cnt < FD) begin
        sb_q.push_back(d);
        model_cnt++;
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic pop_check(input string tag);
    logic [DB-1:0] exp;
    if (sb_q.size() == 0) begin
      check({tag, "_valid"}, rx_valid, 1'b0);
    end else begin
      exp = sb_q.pop_front();
      check({tag, "_valid"}, rx_valid, 1'b1);
      check({tag, "_data"}, rx_data, exp);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      model_cnt--;
    end
  endtask

  // Offer one byte and check every line bit at mid-bit plus tx_ready timing.
  task automatic tx_frame(input logic [DB-1:0] d);
    logic exp;
    int   nb;
    tx_q.push_back(1'b0);
    for (int i = 0; i < DB; i++) tx_q.push_back(d[i]);
    if (PB != 0) tx_q.push_back((^d) ^ 1'(PODD));
    for (int i = 0; i < SB; i++) tx_q.push_back(1'b1);
    nb = tx_q.size();
    check("tx_idle_line", tx_serial, 1'b1);
    check("tx_idle_ready", tx_ready, 1'b1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tx_data  = '0;
    check("tx_start_next_cycle", tx_serial, 1'b0);
    check("tx_ready_low", tx_ready, 1'b0);
    tick(CPB / 2);
    for (int b = 0; b < nb; b++) begin
      exp = tx_q.pop_front();
      check($sformatf("tx_%0h_bit%0d", d, b), tx_serial, exp);
      if (b < nb - 1) tick(CPB);
    end
    tick(CPB / 2 - 1);
    check("tx_ready_before_end", tx_ready, 1'b0);
    tick(1);
    check("tx_ready_return", tx_ready, 1'b1);
    check("tx_line_after", tx_serial, 1'b1);
  endtask

  initial begin
    reset     = 1'b1;
    rx_serial = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = '0;
    rx_ready  = 1'b0;
    err_clear = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);

    check("rst_tx_serial", tx_serial, 1'b1);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, '0);
    check("rst_overflow", rx_overflow, 1'b0);
    check("rst_frame_err", rx_frame_error, 1'b0);
    check("rst_parity_err", rx_parity_error, 1'b0);
    tick(1000);
    check("idle_tx_serial", tx_serial, 1'b1);
    check("idle_tx_ready", tx_ready, 1'b1);
    check("idle_rx_valid", rx_valid, 1'b0);

    tx_frame(8'hA5);
    tx_frame(8'h07);

    send_rx(8'h3C, 1'b1, 1'b0);
    send_rx(8'hFF, 1'b1, 1'b0);
    send_rx(8'h00, 1'b1, 1'b0);
    check("rx_head_valid", rx_valid, 1'b1);
    check("rx_head_data", rx_data, sb_q[0]);
    pop_check("pop_3c");
    pop_check("pop_ff");
    pop_check("pop_00");
    check("rx_drained", rx_valid, 1'b0);
    check("rx_no_overflow", rx_overflow, 1'b0);

    send_rx(8'h11, 1'b1, 1'b0);
    send_rx(8'h22, 1'b1, 1'b0);
    send_rx(8'h33, 1'b1, 1'b0);
    send_rx(8'h44, 1'b1, 1'b0);
    check("full_no_overflow", rx_overflow, 1'b0);
    send_rx(8'h55, 1'b1, 1'b0);
    check("overflow_set", rx_overflow, exp_ovf);
    pop_check("ovf_pop1");
    pop_check("ovf_pop2");
    pop_check("ovf_pop3");
    pop_check("ovf_pop4");
    check("ovf_drained", rx_valid, 1'b0);
    check("overflow_sticky", rx_overflow, 1'b1);
    clear_errors();
    exp_ovf = 1'b0;
    check("overflow_cleared", rx_overflow, exp_ovf);

    send_rx(8'h5A, 1'b0, 1'b0);
    check("ferr_no_push", rx_valid, 1'b0);
    check("ferr_set", rx_frame_error, 1'b1);
    clear_errors();
    check("ferr_cleared", rx_frame_error, 1'b0);

    rx_serial = 1'b0;
    tick(6);
    rx_serial = 1'b1;
    tick(40);
    check("glitch_no_push", rx_valid, 1'b0);
    check("glitch_no_ferr", rx_frame_error, 1'b0);
    send_rx(8'h81, 1'b1, 1'b0);
    pop_check("after_glitch");
    check("after_glitch_drained", rx_valid, 1'b0);

`ifdef UART_PARITY_EN
    send_rx(8'h07, 1'b1, 1'b1);
    check("perr_no_push", rx_valid, 1'b0);
    check("perr_set", rx_parity_error, 1'b1);
    check("perr_no_ferr", rx_frame_error, 1'b0);
    clear_errors();
`endif
    check("parity_err_low", rx_parity_error, 1'b0);

    tx_data  = 8'h00;
    tx_valid = 1'b1;
    tick(1);
    tx_valid  = 1'b0;
    rx_serial = 1'b0;
    tick(20);
    check("midframe_tx_low", tx_serial, 1'b0);
    reset     = 1'b1;
    rx_serial = 1'b1;
    tick(1);
    check("midrst_tx_serial", tx_serial, 1'b1);
    check("midrst_tx_ready", tx_ready, 1'b1);
    reset = 1'b0;
    tick(200);
    check("midrst_rx_lost", rx_valid, 1'b0);
    check("midrst_tx_idle", tx_serial, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
